// File: rtl/mem_stage.sv
// Pipeline MEM stage: holds one instruction, waits for its data response, aligns load
// data, and drops responses that belong to instructions flushed while still in flight.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [127:0] es_to_ms_bus,
  output logic         ms_to_ws_valid,
  output logic [122:0] ms_to_ws_bus,
  output logic [41:0]  ms_to_ds_bus,
  output logic         ms_ex_to_es,
  input  logic         ws_flush,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata
);

  typedef enum logic [2:0] {
    LD_W   = 3'd0,
    LD_B   = 3'd1,
    LD_BU  = 3'd2,
    LD_H   = 3'd3,
    LD_HU  = 3'd4,
    LD_WL  = 3'd5,
    LD_WR  = 3'd6,
    LD_RSV = 3'd7
  } load_op_e;

  logic         ms_valid;
  logic [127:0] ms_bus;
  logic         buf_valid;
  logic [31:0]  buf_data;
  logic [1:0]   discard_cnt;

  logic [31:0]  ms_badvaddr;
  logic [10:0]  ms_c0_bus;
  logic         ms_bd;
  logic         ms_ex;
  logic [4:0]   ms_excode;
  logic         ms_req;
  logic         ms_is_load;
  load_op_e     ms_load_op;
  logic [3:0]   ms_rf_we;
  logic [4:0]   ms_dest;
  logic [31:0]  ms_result;
  logic [31:0]  ms_pc;
  logic [1:0]   addr_lo;

  assign ms_badvaddr = ms_bus[127:96];
  assign ms_c0_bus   = ms_bus[95:85];
  assign ms_bd       = ms_bus[84];
  assign ms_ex       = ms_bus[83];
  assign ms_excode   = ms_bus[82:78];
  assign ms_req      = ms_bus[77];
  assign ms_is_load  = ms_bus[76];
  assign ms_load_op  = load_op_e'(ms_bus[75:73]);
  assign ms_rf_we    = ms_bus[72:69];
  assign ms_dest     = ms_bus[68:64];
  assign ms_result   = ms_bus[63:32];
  assign ms_pc       = ms_bus[31:0];
  assign addr_lo     = ms_result[1:0];

  logic cnt_zero;
  logic rsp_hit;
  logic ms_ready_go;
  logic ms_leave;
  logic buf_capture;
  logic cnt_inc;
  logic cnt_dec;

  // A response only belongs to the current instruction once every stale one is drained.
  assign cnt_zero    = (discard_cnt == 2'd0);
  assign rsp_hit     = buf_valid | (data_sram_data_ok & cnt_zero);
  assign ms_ready_go = ~ms_req | ms_ex | rsp_hit;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~ws_flush;
  assign ms_leave    = ms_to_ws_valid & ws_allowin;
  assign ms_ex_to_es = ms_valid & (ms_ex | ms_c0_bus[10]);

  assign buf_capture = data_sram_data_ok & cnt_zero & ms_valid & ms_req
                     & ~(ws_allowin | ws_flush);
  assign cnt_inc     = ws_flush & ms_valid & ms_req & ~rsp_hit;
  assign cnt_dec     = data_sram_data_ok & ~cnt_zero;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
    end else if (ws_flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (ws_flush || ms_leave) begin
      buf_valid <= 1'b0;
    end else if (buf_capture) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  // Saturates at 3: a fourth outstanding stale response cannot exist with one MEM slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard_cnt <= '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   if (discard_cnt != 2'd3) discard_cnt <= discard_cnt + 2'd1;
        2'b01:   discard_cnt <= discard_cnt - 2'd1;
        default: discard_cnt <= discard_cnt;
      endcase
    end
  end

  logic [31:0] rdata_sel;
  logic [31:0] rdata_shr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_result;
  logic [3:0]  final_we;

  assign rdata_sel = buf_valid ? buf_data : data_sram_rdata;
  assign rdata_shr = rdata_sel >> {addr_lo, 3'b000};
  assign ld_byte   = rdata_shr[7:0];
  assign ld_half   = addr_lo[1] ? rdata_sel[31:16] : rdata_sel[15:0];

  always_comb begin
    final_result = ms_result;
    final_we     = ms_rf_we;
    if (ms_is_load) begin
      case (ms_load_op)
        LD_W: begin
          final_result = rdata_sel;
          final_we     = 4'b1111;
        end
        LD_B: begin
          final_result = {{24{ld_byte[7]}}, ld_byte};
          final_we     = 4'b1111;
        end
        LD_BU: begin
          final_result = {24'd0, ld_byte};
          final_we     = 4'b1111;
        end
        LD_H: begin
          final_result = {{16{ld_half[15]}}, ld_half};
          final_we     = 4'b1111;
        end
        LD_HU: begin
          final_result = {16'd0, ld_half};
          final_we     = 4'b1111;
        end
        LD_WL: begin
          final_result = rdata_sel << {~addr_lo, 3'b000};
          final_we     = 4'b1111 << ~addr_lo;
        end
        LD_WR: begin
          final_result = rdata_shr;
          final_we     = 4'b1111 >> addr_lo;
        end
        default: begin
          final_result = ms_result;
          final_we     = ms_rf_we;
        end
      endcase
    end
    if (ms_ex) begin
      final_we = 4'b0000;
    end
  end

  assign ms_to_ws_bus = {ms_badvaddr, ms_c0_bus, ms_bd, ms_ex, ms_excode,
                         final_we, ms_dest, final_result, ms_pc};

  assign ms_to_ds_bus = {ms_valid & ms_is_load & ~ms_ready_go,
                         final_we & {4{ms_valid}}, ms_dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load alignment, response buffering,
// flush discard of stale responses, exception bypass and reset recovery.
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [127:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [122:0] ms_to_ws_bus;
  logic [41:0]  ms_to_ds_bus;
  logic         ms_ex_to_es;
  logic         ws_flush;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned xfer_cnt;
  int unsigned xfer_base;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .ms_ex_to_es       (ms_ex_to_es),
    .ws_flush          (ws_flush),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so negedge sees a settled handshake.
  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) xfer_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic ex, input logic req, input logic is_load,
                                      input logic [2:0] op, input logic [3:0] we,
                                      input logic [31:0] result, input logic [4:0] excode);
    return {result, 11'd0, 1'b0, ex, excode, req, is_load, op, we, 5'd7, result,
            32'hBFC0_0100};
  endfunction

  task automatic issue(input logic [127:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    #1;
  endtask

  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp_res,
                         input logic [3:0] exp_we);
    issue(mk(1'b0, 1'b1, 1'b1, op, 4'hF, addr, 5'd0));
    check({tag, "_wait"}, ms_to_ws_valid, 32'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    #1;
    check({tag, "_valid"}, ms_to_ws_valid, 32'd1);
    check({tag, "_res"}, ms_to_ws_bus[63:32], exp_res);
    check({tag, "_we"}, ms_to_ws_bus[72:69], exp_we);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; xfer_cnt = 0;
    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    ws_flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("rst_allowin", ms_allowin, 32'd1);
    check("rst_valid", ms_to_ws_valid, 32'd0);
    check("rst_blk", ms_to_ds_bus[41], 32'd0);
    check("rst_ex", ms_ex_to_es, 32'd0);

    issue(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 32'h0000_1234, 5'd0));
    check("alu_valid", ms_to_ws_valid, 32'd1);
    check("alu_res", ms_to_ws_bus[63:32], 32'h0000_1234);
    check("alu_we", ms_to_ws_bus[72:69], 32'hF);
    check("alu_pc", ms_to_ws_bus[31:0], 32'hBFC0_0100);
    check("alu_ds_res", ms_to_ds_bus[31:0], 32'h0000_1234);
    check("alu_ds_dest", ms_to_ds_bus[36:32], 32'd7);
    @(posedge clk); #2;
    check("alu_gone", ms_to_ws_valid, 32'd0);

    issue(mk(1'b0, 1'b1, 1'b1, 3'd1, 4'hF, 32'h0000_1002, 5'd0));
    check("blk_set", ms_to_ds_bus[41], 32'd1);
    check("blk_allowin", ms_allowin, 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0080_FF00; #1;
    check("lb_res", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    check("blk_clr", ms_to_ds_bus[41], 32'd0);
    @(posedge clk); #1 data_sram_data_ok = 1'b0; #1;
    check("lb_gone", ms_to_ws_valid, 32'd0);

    do_load("lbu", 3'd2, 32'h0000_1002, 32'h0080_FF00, 32'h0000_0080, 4'hF);
    do_load("lh",  3'd3, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001, 4'hF);
    do_load("lhu", 3'd4, 32'h0000_2000, 32'h1234_ABCD, 32'h0000_ABCD, 4'hF);
    do_load("lw",  3'd0, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hF);
    do_load("lwl1", 3'd5, 32'h0000_3001, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100);
    do_load("lwl0", 3'd5, 32'h0000_3000, 32'hAABB_CCDD, 32'hDD00_0000, 4'b1000);
    do_load("lwr1", 3'd6, 32'h0000_3001, 32'hAABB_CCDD, 32'h00AA_BBCC, 4'b0111);
    do_load("lwr3", 3'd6, 32'h0000_3003, 32'hAABB_CCDD, 32'h0000_00AA, 4'b0001);

    // Response arrives while WB stalls; word must survive in the buffer.
    ws_allowin = 1'b0;
    xfer_base = xfer_cnt;
    issue(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'hF, 32'h0000_0100, 5'd0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; #1;
    check("buf_valid0", ms_to_ws_valid, 32'd1);
    @(posedge clk); #1 data_sram_data_ok = 1'b0; data_sram_rdata = '0; #1;
    check("buf_hold", dut.buf_valid, 32'd1);
    check("buf_res1", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
    check("buf_stall", ms_allowin, 32'd0);
    @(posedge clk); #1 ws_allowin = 1'b1; #1;
    check("buf_res2", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
    check("buf_valid2", ms_to_ws_valid, 32'd1);
    @(posedge clk); #2;
    check("buf_gone", ms_to_ws_valid, 32'd0);
    check("buf_clear", dut.buf_valid, 32'd0);
    check("buf_xfers", xfer_cnt - xfer_base, 32'd1);

    // Flush while a load waits: its late response must be dropped.
    issue(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'hF, 32'h0000_0200, 5'd0));
    ws_flush = 1'b1; #1;
    check("fl_valid", ms_to_ws_valid, 32'd0);
    @(posedge clk); #1 ws_flush = 1'b0; #1;
    check("fl_msvalid", dut.ms_valid, 32'd0);
    check("fl_cnt1", dut.discard_cnt, 32'd1);
    issue(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'hF, 32'h0000_0204, 5'd0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111; #1;
    check("fl_drop", ms_to_ws_valid, 32'd0);
    @(posedge clk); #1 data_sram_data_ok = 1'b0; #1;
    check("fl_cnt0", dut.discard_cnt, 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222; #1;
    check("fl_next_valid", ms_to_ws_valid, 32'd1);
    check("fl_next_res", ms_to_ws_bus[63:32], 32'h2222_2222);
    @(posedge clk); #1 data_sram_data_ok = 1'b0; #1;

    issue(mk(1'b1, 1'b0, 1'b1, 3'd0, 4'hF, 32'h0000_0123, 5'd4));
    check("ex_valid", ms_to_ws_valid, 32'd1);
    check("ex_we", ms_to_ws_bus[72:69], 32'd0);
    check("ex_to_es", ms_ex_to_es, 32'd1);
    check("ex_bit", ms_to_ws_bus[78], 32'd1);
    check("ex_code", ms_to_ws_bus[77:73], 32'd4);
    check("ex_badv", ms_to_ws_bus[122:91], 32'h0000_0123);
    check("ex_ds_we", ms_to_ds_bus[40:37], 32'd0);
    @(posedge clk); #2;

    // Two stale requests in flight, then reset drops both.
    issue(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'hF, 32'h0000_0300, 5'd0));
    ws_flush = 1'b1; @(posedge clk); #1 ws_flush = 1'b0; #1;
    issue(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'hF, 32'h0000_0304, 5'd0));
    ws_flush = 1'b1; @(posedge clk); #1 ws_flush = 1'b0; #1;
    check("rm_cnt2", dut.discard_cnt, 32'd2);
    issue(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'hF, 32'h0000_0308, 5'd0));
    resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1; #1;
    check("rm_cnt0", dut.discard_cnt, 32'd0);
    check("rm_valid", ms_to_ws_valid, 32'd0);
    check("rm_allowin", ms_allowin, 32'd1);
    do_load("rm_lw", 3'd0, 32'h0000_0400, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL have no parameters; all bus widths below are fixed.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 ws_allowin  in  1  WB stage can accept this cycle.
REQ-005 ms_allowin  out  1  MEM can accept from EX this cycle.
REQ-006 es_to_ms_valid  in  1  EX presents a valid instruction.
REQ-007 es_to_ms_bus  in  128  fields:
- [127:96] badvaddr
- [95:85] c0_bus
- [84] bd
- [83] ex
- [82:78] excode
- [77] req (data request issued, data_ok pending)
- [76] is_load
- [75:73] load_op
- [72:69] rf_we
- [68:64] dest
- [63:32] result (address for memory ops)
- [31:0] pc
REQ-008 ms_to_ws_valid  out  1  MEM presents a valid instruction to WB.
REQ-009 ms_to_ws_bus  out  123  fields:
- [122:91] badvaddr
- [90:80] c0_bus
- [79] bd
- [78] ex
- [77:73] excode
- [72:69] rf_we
- [68:64] dest
- [63:32] final_result
- [31:0] pc
REQ-010 ms_to_ds_bus  out  42  forward bus: [41] blk, [40:37] rf_we, [36:32] dest, [31:0] final_result.
REQ-011 ms_ex_to_es  out  1  ms_valid & (ex | c0_bus[10]); EX suppresses stores.
REQ-012 ws_flush  in  1  WB exception or eret this cycle.
REQ-013 data_sram_data_ok  in  1  one in-order response for a data request.
REQ-014 data_sram_rdata  in  32  read data, valid with data_ok.

Function
REQ-015 ms_valid SHALL clear on ws_flush, else load es_to_ms_valid when ms_allowin; the bus register SHALL load on es_to_ms_valid & ms_allowin.
REQ-016 ms_ready_go SHALL be 1 when !req | ex | rsp_hit, where rsp_hit = buf_valid | (data_ok & discard_cnt==0).
REQ-017 ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go & !ws_flush.
REQ-018 Response buffer (32-bit data + buf_valid): SHALL capture rdata when data_ok & discard_cnt==0 & ms_valid & req & !(ws_allowin | ws_flush), and SHALL clear when the instruction leaves or is flushed.
REQ-019 Discard counter (2 bits, reset 0): +1 on ws_flush while ms_valid & req & !rsp_hit; -1 on each data_ok while nonzero, with that response dropped; simultaneous +1/-1 SHALL net 0; counter SHALL never wrap past 3.
REQ-020 Load data uses a = result[1:0] and rdata from the buffer if buf_valid, else data_sram_rdata.
REQ-021 load_op 000 lw: rdata, rf_we 1111.
REQ-022 load_op 001 lb / 010 lbu: byte a, sign- or zero-extended.
REQ-023 load_op 011 lh / 100 lhu: half a[1], sign- or zero-extended.
REQ-024 load_op 101 lwl: a=0 rdata<<24 we 1000; a=1 <<16 we 1100; a=2 <<8 we 1110; a=3 unshifted we 1111.
REQ-025 load_op 110 lwr: a=0 unshifted we 1111; a=1 >>8 we 0111; a=2 >>16 we 0011; a=3 >>24 we 0001.
REQ-026 For non-loads, final_result = result and rf_we passes through; when ex=1, rf_we SHALL be forced to 0000.
REQ-027 ms_to_ds_bus: blk = ms_valid & is_load & !ms_ready_go; rf_we gated by ms_valid.
REQ-028 All other ms_to_ws_bus fields SHALL pass through unchanged.
REQ-029 Latency: a non-memory instruction SHALL forward in the cycle after entry; a load SHALL forward in its data_ok cycle when ws_allowin=1.

Reset
REQ-030 While resetn=0 at a clock edge: ms_valid=0, buf_valid=0, discard_cnt=0.
REQ-031 After reset: ms_allowin=1, ms_to_ws_valid=0, blk=0, ms_ex_to_es=0.
REQ-032 Reset mid-transaction SHALL drop all pending responses without a counter update.

Verification
REQ-033 ALU op, result=0x1234, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234.
REQ-034 lb, addr low bits=2, rdata=0x0080FF00 -> final_result=0xFFFFFF80; lbu -> 0x00000080.
REQ-035 lwl, a=1, rdata=0xAABBCCDD -> final_result=0xCCDD0000, rf_we=1100; lwr a=1 -> 0x00AABBCC, rf_we 0111.
REQ-036 lw with data_ok=1 while ws_allowin=0 -> buffer holds the data; ws_allowin=1 two cycles later -> correct word delivered, exactly one transfer.
REQ-037 ws_flush while lw pending -> ms_valid=0, discard_cnt=1; next data_ok dropped, cnt=0; following lw completes normally.
REQ-038 ex=1 load with req=0 -> ready_go immediately, rf_we=0000, ms_ex_to_es=1.
